// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for the two-input AND/OR gates.
// Sweeps {a,b} through 00,01,10,11 and checks both gate outputs against the truth table.
module gate_bist_ctrl #(
    parameter int HOLD_CYCLES = 1,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             and_i,
    input  logic             or_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             pass_q, pass_d;

    logic             hold_end;
    logic             mis_and;
    logic             mis_or;
    logic [ERR_W:0]   err_sum;
    logic [ERR_W-1:0] err_sat;

    assign hold_end = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    assign mis_and  = (and_i != (idx_q[1] & idx_q[0]));
    assign mis_or   = (or_i != (idx_q[1] | idx_q[0]));
    // At most +2 per vector, so one extra sum bit is enough to detect overflow.
    assign err_sum  = {1'b0, err_q} + (ERR_W+1)'(mis_and) + (ERR_W+1)'(mis_or);
    assign err_sat  = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (start) begin
                    state_d = DRIVE;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (hold_end) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                err_d = err_sat;
                if (mis_and || mis_or) begin
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    idx_d   = '0;
                    pass_d  = (err_sat == '0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == DRIVE) || (state_q == CHECK);
        done      = (state_q == DONE);
        a_o       = busy & idx_q[1];
        b_o       = busy & idx_q[0];
        pass      = pass_q;
        err_count = err_q;
        fail_vec  = fail_q;
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: three instances cover default,
// narrow error counter and long hold configurations.
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] start_v = '0;
    int   mode = 0;
    int   sel = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // mode 0 good, 1 AND stuck-0, 2 AND/OR swapped, 3 both inverted
    function automatic logic [1:0] gate(input int m, input logic a, input logic b);
        logic g_and;
        logic g_or;
        g_and = a & b;
        g_or  = a | b;
        case (m)
            1:       return {1'b0, g_or};
            2:       return {g_or, g_and};
            3:       return {~g_and, ~g_or};
            default: return {g_and, g_or};
        endcase
    endfunction

    logic a0, b0, and0, or0, busy0, done0, pass0;
    logic [3:0] err0, fv0;
    logic a1, b1, and1, or1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [3:0] fv1;
    logic a2, b2, and2, or2, busy2, done2, pass2;
    logic [3:0] err2, fv2;

    assign {and0, or0} = gate(mode, a0, b0);
    assign {and1, or1} = gate(mode, a1, b1);
    assign {and2, or2} = gate(mode, a2, b2);

    gate_bist_ctrl u_def (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .a_o(a0), .b_o(b0), .and_i(and0), .or_i(or0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0)
    );

    gate_bist_ctrl #(.HOLD_CYCLES(1), .ERR_W(2)) u_narrow (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .a_o(a1), .b_o(b1), .and_i(and1), .or_i(or1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    gate_bist_ctrl #(.HOLD_CYCLES(3), .ERR_W(4)) u_hold (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .a_o(a2), .b_o(b2), .and_i(and2), .or_i(or2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fv2)
    );

    logic       t_a, t_b, t_busy, t_done, t_pass;
    logic [3:0] t_err, t_fv;

    always_comb begin
        t_a = a0; t_b = b0; t_busy = busy0; t_done = done0;
        t_pass = pass0; t_err = err0; t_fv = fv0;
        if (sel == 1) begin
            t_a = a1; t_b = b1; t_busy = busy1; t_done = done1;
            t_pass = pass1; t_err = {2'b00, err1}; t_fv = fv1;
        end else if (sel == 2) begin
            t_a = a2; t_b = b2; t_busy = busy2; t_done = done2;
            t_pass = pass2; t_err = err2; t_fv = fv2;
        end
    end

    task automatic chk_idle(input string tag);
        checks++;
        if ({t_a, t_b, t_busy, t_done, t_pass, t_err, t_fv} !== 13'd0) begin
            errors++;
            $display("FAIL %s: ab=%b%b busy=%b done=%b pass=%b err=%0d fv=%b, want all 0",
                     tag, t_a, t_b, t_busy, t_done, t_pass, t_err, t_fv);
        end
    endtask

    task automatic chk_results(input string tag, input logic ep,
                               input logic [3:0] ee, input logic [3:0] ef);
        checks++;
        if (t_pass !== ep || t_err !== ee || t_fv !== ef) begin
            errors++;
            $display("FAIL %s: pass=%b err=%0d fv=%b, want pass=%b err=%0d fv=%b",
                     tag, t_pass, t_err, t_fv, ep, ee, ef);
        end
    endtask

    // Pulses start at edge T0; sample n is taken in cycle T0+n.
    task automatic sweep(input int hold, input logic ep, input logic [3:0] ee,
                         input logic [3:0] ef, input bit extra, input bit restart);
        int last;
        int dones;
        logic [1:0] k;
        last  = 1 + 4 * (hold + 1);
        dones = 0;
        @(negedge clk) start_v[sel] = 1'b1;
        @(negedge clk) start_v[sel] = 1'b0;
        for (int n = 1; n <= last; n++) begin
            if (n > 1) @(negedge clk);
            if (t_done) dones++;
            if (n < last) begin
                k = 2'((n - 1) / (hold + 1));
                checks++;
                if ({t_a, t_b} !== k || t_busy !== 1'b1 || t_done !== 1'b0) begin
                    errors++;
                    $display("FAIL drive n=%0d: ab=%b%b busy=%b done=%b, want ab=%b busy=1 done=0",
                             n, t_a, t_b, t_busy, t_done, k);
                end
            end else begin
                checks++;
                if (t_done !== 1'b1 || t_busy !== 1'b0 || {t_a, t_b} !== 2'b00) begin
                    errors++;
                    $display("FAIL done_cycle n=%0d: done=%b busy=%b ab=%b%b, want 1 0 00",
                             n, t_done, t_busy, t_a, t_b);
                end
                chk_results("results_at_done", ep, ee, ef);
            end
            if (extra && (n == 3 || n == 6 || n == 10)) start_v[sel] = 1'b1;
            else start_v[sel] = 1'b0;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, want 1", dones);
        end
        @(negedge clk);
        checks++;
        if (t_done !== 1'b0 || t_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b, want 0 0", t_done, t_busy);
        end
        chk_results("results_hold", ep, ee, ef);
        if (restart) start_v[sel] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            chk_idle("reset_state");
        end
        rst = 1'b0;
        sel = 0;
    endtask

    task automatic test_good();
        sel = 0; mode = 0;
        sweep(1, 1'b1, 4'd0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_and_stuck();
        sel = 0; mode = 1;
        sweep(1, 1'b0, 4'd1, 4'b1000, 1'b0, 1'b0);
    endtask

    task automatic test_swapped();
        sel = 0; mode = 2;
        sweep(1, 1'b0, 4'd4, 4'b0110, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        sel = 1; mode = 3;
        sweep(1, 1'b0, 4'd3, 4'b1111, 1'b0, 1'b0);
    endtask

    task automatic test_hold_restart();
        sel = 2; mode = 3;
        sweep(3, 1'b0, 4'd8, 4'b1111, 1'b1, 1'b1);
        @(negedge clk) start_v[2] = 1'b0;
        checks++;
        if ({t_a, t_b} !== 2'b00 || t_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: ab=%b%b busy=%b, want 00 1", t_a, t_b, t_busy);
        end
        chk_results("restart_cleared", 1'b0, 4'd0, 4'b0000);
        repeat (20) @(negedge clk);
        mode = 0;
    endtask

    task automatic test_rst_mid();
        int dones;
        sel = 0; mode = 3;
        dones = 0;
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({t_a, t_b} !== 2'b10 || t_err !== 4'd4) begin
            errors++;
            $display("FAIL pre_rst: ab=%b%b err=%0d, want 10 4", t_a, t_b, t_err);
        end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk_idle("rst_mid_sweep");
        repeat (12) begin
            @(negedge clk);
            if (t_done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d pulses, want 0", dones);
        end
        mode = 0;
        sweep(1, 1'b1, 4'd0, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good();
        test_and_stuck();
        test_swapped();
        test_saturate();
        test_hold_restart();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Self-test sequencer for the two-input logic gates (`and_m`, `or_m`). It owns the shared `a`/`b` operand pair and drives it through all four input combinations on command. It samples both gate outputs against the expected truth table and reports pass/fail, a mismatch count and a per-vector failure map. It sits beside the gate instances and replaces free-running stimulus with a repeatable, handshaked sweep.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: settle cycles each vector is driven before sampling; legal range ≥ 1.
- `ERR_W`, default 4: width of the mismatch counter; legal range ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `a_o`  out  1  operand a to both gates.
- `b_o`  out  1  operand b to both gates.
- `and_i`  in  1  AND gate output.
- `or_i`  in  1  OR gate output.
- `busy`  out  1  high while in DRIVE or CHECK.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `pass`  out  1  sweep result; valid from `done` until the next accepted `start`.
- `err_count`  out  ERR_W  saturating count of output mismatches.
- `fail_vec`  out  4  bit i set if vector i had any mismatch; i = {a,b}.

## Operation
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - `a_o`, `b_o` = 0.
  - `start` = 1 → DRIVE with vector index 0.
  - On the accepting edge, `err_count`, `fail_vec` and `pass` clear to 0.
- DRIVE:
  - Drives {`a_o`,`b_o`} = vector index.
  - Stays exactly HOLD_CYCLES cycles, then moves to CHECK.
- CHECK:
  - One cycle; the vector is still driven.
  - Compares `and_i` with a&b and `or_i` with a|b.
  - Each mismatching output adds 1 to `err_count`, so 0, 1 or 2 per vector.
  - Any mismatch sets `fail_vec[index]`.
  - Next state: index < 3 → increment index, go to DRIVE; index = 3 → DONE.
- DONE:
  - One cycle: `done` = 1, `pass` = (`err_count` == 0), operands return to 0.
  - Unconditionally → IDLE.
- Vector order is 00, 01, 10, 11 as {a,b}.
- `err_count` saturates at 2^ERR_W−1 and never wraps.
- `start` in DRIVE, CHECK or DONE is ignored and not queued. `start` held high re-triggers from IDLE.
- Results (`pass`, `err_count`, `fail_vec`) hold in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, vector index 0. Outputs `a_o`, `b_o`, `busy`, `done`, `pass` = 0; `err_count` = 0; `fail_vec` = 0.
- Reset wins over every other event. Asserted mid-sweep, it aborts the sweep with no `done` pulse; all outputs take their reset values on the next edge.
- `start` is sampled at edge T0.
  - Vector 0 is on `a_o`/`b_o` and `busy` = 1 from cycle T0+1.
  - Vector k is driven over cycles T0+1+k·(HOLD_CYCLES+1) … T0+(k+1)·(HOLD_CYCLES+1).
  - Vector k's last cycle is its CHECK cycle.
- `done` is high in cycle T0+1+4·(HOLD_CYCLES+1). That is cycle T0+9 for HOLD_CYCLES=1 and T0+17 for HOLD_CYCLES=3.
- `busy` = 0 in the `done` cycle.
- The earliest re-start is `start` sampled in the cycle after `done`.
- Gate inputs are sampled at the end of CHECK. `err_count`/`fail_vec` updates are visible the cycle after CHECK.
- No combinational path from `and_i`/`or_i` to any output.

## Test plan
- Correct gates, HOLD_CYCLES=1, `start` pulsed at T0 → operands 00, 01, 10, 11 for 2 cycles each; `done` at T0+9; `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
- `and_i` stuck at 0 → only vector 11 fails; `done` at T0+9; `pass`=0, `err_count`=1, `fail_vec`=4'b1000.
- `and_i`/`or_i` swapped → vectors 01 and 10 fail on both outputs; `err_count`=4, `fail_vec`=4'b0110, `pass`=0.
- ERR_W=2, both gate outputs inverted → 8 mismatches; `err_count` saturates at 3; `fail_vec`=4'b1111.
- HOLD_CYCLES=3: extra `start` pulses in DRIVE/CHECK are ignored; `done` exactly at T0+17. A new `start` in the cycle after `done` → vector 0 driven the following cycle and results cleared.
- `rst` asserted during CHECK of vector 2 → next cycle IDLE with all outputs 0 and no `done` pulse. A subsequent sweep completes normally with `pass`=1.
